// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester and memory-bus signal bundle for mem_bus_arbiter
interface mem_bus_arbiter_if;
  logic        i_ren;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_busy;
  logic        d_ren;
  logic        d_wen;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_busy;
  logic        d_fault;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_rdata;
  logic        bus_busy;

  // Requesters plus memory subsystem: everything around the arbiter
  modport master (
    output i_ren, i_addr, d_ren, d_wen, d_funct3, d_addr, d_wdata, bus_rdata, bus_busy,
    input  i_rdata, i_busy, d_rdata, d_busy, d_fault,
    input  bus_ren, bus_wen, bus_addr, bus_wdata, bus_byte_en
  );

  modport slave (
    input  i_ren, i_addr, d_ren, d_wen, d_funct3, d_addr, d_wdata, bus_rdata, bus_busy,
    output i_rdata, i_busy, d_rdata, d_busy, d_fault,
    output bus_ren, bus_wen, bus_addr, bus_wdata, bus_byte_en
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory bus between instruction fetch and load/store
module mem_bus_arbiter #(
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  mem_bus_arbiter_if.slave mb
);
  localparam int SW = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t      state;
  logic [SW-1:0] streak;
  logic [2:0]  ld_funct3;

  logic        dreq, fault_now, dreq_ok, grant_i, grant_d, d_done, idle;
  logic [3:0]  be_now;
  logic [31:0] wdata_now;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign idle    = (state == IDLE);
  assign dreq    = mb.d_ren | mb.d_wen;
  assign dreq_ok = dreq & ~fault_now;
  assign grant_i = idle & mb.i_ren & (~dreq_ok | (streak == STREAK_MAX));
  assign grant_d = idle & dreq_ok & ~grant_i;
  assign d_done  = ((state == GNT_D) & ~mb.bus_busy) | (idle & fault_now);

  assign mb.i_busy  = mb.i_ren & ~((state == GNT_I) & ~mb.bus_busy);
  assign mb.d_busy  = dreq & ~d_done;
  assign mb.d_fault = idle & fault_now;
  assign mb.i_rdata = mb.bus_rdata;

  always_comb begin
    fault_now = 1'b0;
    if (mb.d_ren & mb.d_wen)
      fault_now = 1'b1;
    else if (mb.d_ren && (mb.d_funct3 == 3'b011 || mb.d_funct3 == 3'b110 || mb.d_funct3 == 3'b111))
      fault_now = 1'b1;
    else if (mb.d_wen && mb.d_funct3 >= 3'b011)
      fault_now = 1'b1;
    if (dreq && mb.d_funct3[1:0] == 2'b01 && mb.d_addr[0])
      fault_now = 1'b1;
    if (dreq && mb.d_funct3[1:0] == 2'b10 && mb.d_addr[1:0] != 2'b00)
      fault_now = 1'b1;
  end

  always_comb begin
    be_now    = 4'b1111;
    wdata_now = mb.d_wdata;
    case (mb.d_funct3[1:0])
      2'b00: begin
        be_now    = 4'b0001 << mb.d_addr[1:0];
        wdata_now = {4{mb.d_wdata[7:0]}};
      end
      2'b01: begin
        be_now    = mb.d_addr[1] ? 4'b1100 : 4'b0011;
        wdata_now = {2{mb.d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the latched address, so it is stable for the whole grant
  always_comb begin
    lane_byte = mb.bus_rdata[7:0];
    case (mb.bus_addr[1:0])
      2'b01:   lane_byte = mb.bus_rdata[15:8];
      2'b10:   lane_byte = mb.bus_rdata[23:16];
      2'b11:   lane_byte = mb.bus_rdata[31:24];
      default: ;
    endcase
    lane_half = mb.bus_addr[1] ? mb.bus_rdata[31:16] : mb.bus_rdata[15:0];
    case (ld_funct3)
      3'b000:  mb.d_rdata = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  mb.d_rdata = {24'd0, lane_byte};
      3'b001:  mb.d_rdata = {{16{lane_half[15]}}, lane_half};
      3'b101:  mb.d_rdata = {16'd0, lane_half};
      default: mb.d_rdata = mb.bus_rdata;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state          <= IDLE;
      streak         <= '0;
      ld_funct3      <= 3'b010;
      mb.bus_ren     <= 1'b0;
      mb.bus_wen     <= 1'b0;
      mb.bus_addr    <= 32'd0;
      mb.bus_wdata   <= 32'd0;
      mb.bus_byte_en <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!mb.i_ren)
            streak <= '0;
          if (grant_i) begin
            state          <= GNT_I;
            streak         <= '0;
            mb.bus_ren     <= 1'b1;
            mb.bus_wen     <= 1'b0;
            mb.bus_addr    <= mb.i_addr;
            mb.bus_byte_en <= 4'b1111;
          end else if (grant_d) begin
            state          <= GNT_D;
            mb.bus_ren     <= mb.d_ren;
            mb.bus_wen     <= mb.d_wen;
            mb.bus_addr    <= mb.d_addr;
            mb.bus_wdata   <= wdata_now;
            mb.bus_byte_en <= be_now;
            ld_funct3      <= mb.d_funct3;
            if (mb.i_ren && streak != STREAK_MAX)
              streak <= streak + SW'(1);
          end
        end
        default: begin
          if (!mb.bus_busy) begin
            state      <= IDLE;
            mb.bus_ren <= 1'b0;
            mb.bus_wen <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  be_q[$];
  logic        grant_q[$];

  logic        obs_pre, obs_pre_busy, obs_hold_busy, obs_ren, obs_wen;
  logic        obs_busy, obs_fault, obs_bubble;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  int          obs_lat;

  mem_bus_arbiter_if bif();

  mem_bus_arbiter #(.DATA_STREAK_MAX(4)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .mb  (bif.slave)
  );

  always #5 CLK = ~CLK;

  task automatic clear_req();
    bif.i_ren    = 1'b0;
    bif.d_ren    = 1'b0;
    bif.d_wen    = 1'b0;
    bif.bus_busy = 1'b1;
  endtask

  // Entered and left at #1 after a rising edge with the arbiter idle
  task automatic txn(input bit f, input bit ren, input bit wen, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] brd, input int hold);
    int n;
    if (f) begin
      bif.i_ren  = 1'b1;
      bif.i_addr = addr;
    end else begin
      bif.d_ren    = ren;
      bif.d_wen    = wen;
      bif.d_funct3 = f3;
      bif.d_addr   = addr;
      bif.d_wdata  = wdata;
    end
    bif.bus_busy = 1'b1;
    @(negedge CLK);
    obs_pre      = bif.bus_ren | bif.bus_wen;
    obs_pre_busy = f ? bif.i_busy : bif.d_busy;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(bif.bus_ren | bif.bus_wen) && n < 8);
    obs_lat   = n;
    obs_ren   = bif.bus_ren;
    obs_wen   = bif.bus_wen;
    obs_be    = bif.bus_byte_en;
    obs_addr  = bif.bus_addr;
    obs_wdata = bif.bus_wdata;
    obs_hold_busy = f ? bif.i_busy : bif.d_busy;
    repeat (hold) begin
      @(negedge CLK);
      obs_hold_busy &= f ? bif.i_busy : bif.d_busy;
    end
    bif.bus_busy  = 1'b0;
    bif.bus_rdata = brd;
    #1;
    obs_busy  = f ? bif.i_busy : bif.d_busy;
    obs_rdata = f ? bif.i_rdata : bif.d_rdata;
    obs_fault = bif.d_fault;
    @(posedge CLK);
    #1;
    clear_req();
    obs_bubble = bif.bus_ren | bif.bus_wen;
  endtask

  task automatic test_reset();
    nRST      = 1'b0;
    bif.i_ren = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if ({bif.bus_ren, bif.bus_wen} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b want=00", {bif.bus_ren, bif.bus_wen}); end
    checks++; if (bif.bus_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got=%h want=0", bif.bus_addr); end
    checks++; if (bif.bus_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h want=0", bif.bus_wdata); end
    checks++; if (bif.bus_byte_en !== 4'd0) begin errors++; $display("FAIL reset_be got=%b want=0000", bif.bus_byte_en); end
    checks++; if (bif.i_busy !== 1'b1) begin errors++; $display("FAIL reset_i_busy got=%b want=1", bif.i_busy); end
    checks++; if (bif.d_busy !== 1'b0) begin errors++; $display("FAIL reset_d_busy got=%b want=0", bif.d_busy); end
    @(posedge CLK);
    #1;
    clear_req();
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_fetch();
    exp_q.push_back(32'hDEADBEEF);
    txn(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    checks++; if (obs_pre !== 1'b0) begin errors++; $display("FAIL fetch_idle_strobe got=%b want=0", obs_pre); end
    checks++; if (obs_pre_busy !== 1'b1) begin errors++; $display("FAIL fetch_idle_busy got=%b want=1", obs_pre_busy); end
    checks++; if (obs_lat !== 1) begin errors++; $display("FAIL fetch_latency got=%0d want=1", obs_lat); end
    checks++; if ({obs_ren, obs_wen} !== 2'b10) begin errors++; $display("FAIL fetch_strobe got=%b want=10", {obs_ren, obs_wen}); end
    checks++; if (obs_be !== 4'b1111) begin errors++; $display("FAIL fetch_be got=%b want=1111", obs_be); end
    checks++; if (obs_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr got=%h want=100", obs_addr); end
    checks++; if (obs_hold_busy !== 1'b1) begin errors++; $display("FAIL fetch_hold_busy got=%b want=1", obs_hold_busy); end
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL fetch_done_busy got=%b want=0", obs_busy); end
    checks++; if (obs_rdata !== exp_q.pop_front()) begin errors++; $display("FAIL fetch_rdata got=%h want=deadbeef", obs_rdata); end
    checks++; if (obs_bubble !== 1'b0) begin errors++; $display("FAIL fetch_bubble got=%b want=0", obs_bubble); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3[5]  = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101};
    logic [31:0] ad[5]  = '{32'h203, 32'h203, 32'h202, 32'h204, 32'h200};
    logic [31:0] rd[5]  = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h12345678, 32'h00008001};
    logic [31:0] ex[5]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h12345678, 32'h00008001};
    logic [3:0]  eb[5]  = '{4'b1000, 4'b1000, 4'b1100, 4'b1111, 4'b0011};
    logic [31:0] want;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ex[i]);
      be_q.push_back(eb[i]);
      txn(1'b0, 1'b1, 1'b0, f3[i], ad[i], 32'h0, rd[i], i % 2);
      want = exp_q.pop_front();
      checks++; if (obs_rdata !== want) begin errors++; $display("FAIL load%0d_rdata got=%h want=%h", i, obs_rdata, want); end
      checks++; if (obs_be !== be_q.pop_front()) begin errors++; $display("FAIL load%0d_be got=%b want=%b", i, obs_be, eb[i]); end
      checks++; if ({obs_ren, obs_wen, obs_lat} !== {2'b10, 32'd1}) begin errors++; $display("FAIL load%0d_strobe got=%b%b lat=%0d want=10 lat=1", i, obs_ren, obs_wen, obs_lat); end
      checks++; if ({obs_busy, obs_fault} !== 2'b00) begin errors++; $display("FAIL load%0d_done got=%b want=00", i, {obs_busy, obs_fault}); end
      checks++; if (obs_addr !== ad[i]) begin errors++; $display("FAIL load%0d_addr got=%h want=%h", i, obs_addr, ad[i]); end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3[3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] ad[3] = '{32'h302, 32'h301, 32'h304};
    logic [31:0] wd[3] = '{32'h1234ABCD, 32'h0000775A, 32'hCAFE1234};
    logic [31:0] ew[3] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'hCAFE1234};
    logic [3:0]  eb[3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] want;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ew[i]);
      be_q.push_back(eb[i]);
      txn(1'b0, 1'b0, 1'b1, f3[i], ad[i], wd[i], 32'h0, 1);
      want = exp_q.pop_front();
      checks++; if (obs_wdata !== want) begin errors++; $display("FAIL store%0d_wdata got=%h want=%h", i, obs_wdata, want); end
      checks++; if (obs_be !== be_q.pop_front()) begin errors++; $display("FAIL store%0d_be got=%b want=%b", i, obs_be, eb[i]); end
      checks++; if ({obs_ren, obs_wen} !== 2'b01) begin errors++; $display("FAIL store%0d_strobe got=%b want=01", i, {obs_ren, obs_wen}); end
      checks++; if ({obs_busy, obs_bubble} !== 2'b00) begin errors++; $display("FAIL store%0d_done got=%b want=00", i, {obs_busy, obs_bubble}); end
    end
  endtask

  task automatic test_faults();
    logic        rn[3] = '{1'b1, 1'b0, 1'b1};
    logic        wn[3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]  f3[3] = '{3'b010, 3'b011, 3'b000};
    logic [31:0] ad[3] = '{32'h401, 32'h404, 32'h408};
    for (int i = 0; i < 3; i++) begin
      bif.d_ren    = rn[i];
      bif.d_wen    = wn[i];
      bif.d_funct3 = f3[i];
      bif.d_addr   = ad[i];
      #1;
      checks++; if ({bif.d_busy, bif.d_fault} !== 2'b01) begin errors++; $display("FAIL fault%0d_resp got=%b want=01", i, {bif.d_busy, bif.d_fault}); end
      @(posedge CLK);
      #1;
      checks++; if ({bif.bus_ren, bif.bus_wen} !== 2'b00) begin errors++; $display("FAIL fault%0d_no_grant got=%b want=00", i, {bif.bus_ren, bif.bus_wen}); end
      clear_req();
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_starvation();
    int n;
    logic want;
    for (int r = 0; r < 2; r++) begin
      repeat (4) grant_q.push_back(1'b0);
      grant_q.push_back(1'b1);
    end
    bif.i_ren    = 1'b1;
    bif.i_addr   = 32'h500;
    bif.d_ren    = 1'b1;
    bif.d_funct3 = 3'b010;
    bif.d_addr   = 32'h600;
    bif.bus_busy = 1'b0;
    n = 0;
    while (grant_q.size() > 0 && n < 40) begin
      @(negedge CLK);
      n++;
      if (bif.bus_ren) begin
        want = grant_q.pop_front();
        checks++;
        if ((bif.bus_addr == 32'h500) !== want) begin
          errors++;
          $display("FAIL starve_grant got_fetch=%b want_fetch=%b left=%0d", bif.bus_addr == 32'h500, want, grant_q.size());
        end
      end
    end
    checks++; if (grant_q.size() != 0) begin errors++; $display("FAIL starve_timeout got=%0d left want=0", grant_q.size()); end
    grant_q.delete();
    @(posedge CLK);
    #1;
    clear_req();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_mid();
    bif.d_ren    = 1'b1;
    bif.d_funct3 = 3'b010;
    bif.d_addr   = 32'h700;
    bif.bus_busy = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (bif.bus_ren !== 1'b1) begin errors++; $display("FAIL rmid_granted got=%b want=1", bif.bus_ren); end
    nRST = 1'b0;
    #1;
    checks++; if ({bif.bus_ren, bif.bus_byte_en, bif.bus_addr} !== 37'd0) begin errors++; $display("FAIL rmid_clear got=%b %b %h want=0 0000 0", bif.bus_ren, bif.bus_byte_en, bif.bus_addr); end
    checks++; if (bif.d_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got=%b want=1", bif.d_busy); end
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    checks++; if (bif.bus_ren !== 1'b0) begin errors++; $display("FAIL rmid_idle got=%b want=0", bif.bus_ren); end
    @(negedge CLK);
    checks++; if ({bif.bus_ren, bif.bus_addr} !== {1'b1, 32'h700}) begin errors++; $display("FAIL rmid_regrant got=%b %h want=1 700", bif.bus_ren, bif.bus_addr); end
    exp_q.push_back(32'hCAFEF00D);
    bif.bus_busy  = 1'b0;
    bif.bus_rdata = 32'hCAFEF00D;
    #1;
    checks++; if ({bif.d_busy, bif.d_rdata} !== {1'b0, exp_q.pop_front()}) begin errors++; $display("FAIL rmid_done got=%b %h want=0 cafef00d", bif.d_busy, bif.d_rdata); end
    @(posedge CLK);
    #1;
    clear_req();
  endtask

  initial begin
    bif.i_ren     = 1'b0;
    bif.i_addr    = 32'd0;
    bif.d_ren     = 1'b0;
    bif.d_wen     = 1'b0;
    bif.d_funct3  = 3'b010;
    bif.d_addr    = 32'd0;
    bif.d_wdata   = 32'd0;
    bif.bus_rdata = 32'd0;
    bif.bus_busy  = 1'b1;
    test_reset();
    test_fetch();
    test_loads();
    test_stores();
    test_faults();
    test_starvation();
    test_reset_mid();
    repeat (2) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences the single shared memory bus between instruction fetch and the data path (LOAD/STORE opcodes).
- Generates byte enables and store-lane replication from the load/store funct3 encodings.
- Sign- or zero-extends load data.
- Detects misaligned or illegal accesses.
- Sits between the fetch/execute stages and the generic bus to the memory subsystem.

Parameters:
- DATA_STREAK_MAX, 4: maximum consecutive data grants while a fetch request waits; the next arbitration then goes to fetch.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- i_ren  in  1  fetch read request
- i_addr  in  32  fetch address
- i_rdata  out  32  fetch data, raw word
- i_busy  out  1  fetch not complete
- d_ren  in  1  data load request
- d_wen  in  1  data store request
- d_funct3  in  3  load_t/store_t encoding
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified
- d_rdata  out  32  extended load data
- d_busy  out  1  data not complete
- d_fault  out  1  misaligned/illegal access, valid when d_busy=0
- bus_ren  out  1  bus read strobe
- bus_wen  out  1  bus write strobe
- bus_addr  out  32  bus address
- bus_wdata  out  32  lane-aligned store data
- bus_byte_en  out  4  lane enables
- bus_rdata  in  32  bus read data
- bus_busy  in  1  bus transaction in progress; 0 means complete this cycle

Behaviour:
- Clocking and reset: one clock CLK, positive edge. Reset is asynchronous and active-low (nRST).
- On reset, go to IDLE and clear all bus outputs (bus_ren, bus_wen, bus_addr, bus_wdata, bus_byte_en) and the streak counter to 0. A transaction in flight is abandoned.
- Busy outputs are combinational:
  - i_busy = i_ren & !(GNT_I & !bus_busy).
  - d_busy = (d_ren|d_wen) & !d_done.
  - d_done = (GNT_D & !bus_busy) | (IDLE & fault_now).
  - Consequence: during reset, busy equals the request.
- States and transitions:
  - IDLE: no bus strobe.
    - A data request that faults completes in the same cycle with d_fault=1, no grant and no bus access.
    - Otherwise, grant to fetch if i_ren & (!dreq_ok | streak==DATA_STREAK_MAX); else grant to data if dreq_ok; else stay in IDLE.
    - The grant registers bus_addr/bus_wdata/bus_byte_en/strobes at the edge. The bus sees the request one cycle after it is first seen in IDLE.
  - GNT_I: bus_ren=1, bus_byte_en=4'b1111, bus_addr=latched i_addr.
  - GNT_D: strobe=bus_wen for a store, bus_ren for a load, with the latched address/data/enables.
  - In either GNT state, when bus_busy=0: the requester completes that cycle, strobes drop at the edge, and the state returns to IDLE. There is a minimum one-cycle bubble between transactions.
- Requester contract:
  - Hold request and operands stable until busy=0.
  - Drop or change the request in the cycle after completion.
  - Operand changes during a grant are ignored because they are latched.
- Faults (fault_now): any of
  - d_ren & d_wen;
  - load funct3 in {011,110,111};
  - store funct3 >= 011;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- Byte enables:
  - byte: 1<<addr[1:0];
  - half: addr[1]? 1100 : 0011;
  - word: 1111.
- Store data:
  - SB replicates wdata[7:0] across 4 lanes.
  - SH replicates wdata[15:0] twice.
  - SW passes through.
- Load data: d_rdata is combinational from bus_rdata during completion. The lane is selected by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Value outside completion is don't-care.
- i_rdata = bus_rdata.
- bus_addr carries the full byte address; low bits are not cleared.
- Streak counter (saturating at DATA_STREAK_MAX):
  - Increments on each data grant while i_ren=1.
  - Clears on a fetch grant or whenever i_ren=0 in IDLE.

Test Plan:
- Fetch only: i_ren=1, i_addr=0x100, bus_busy high 2 cycles then low, bus_rdata=0xDEADBEEF -> bus_ren rises 1 cycle after request; i_busy low in completion cycle with i_rdata=0xDEADBEEF; 1-cycle bubble.
- Loads: LB at 0x203 with bus_rdata=0x80FF_0000 -> byte_en=1000, d_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x202 -> 0xFFFF80FF.
- Store: SH, d_addr=0x302, d_wdata=0x1234ABCD -> bus_wen=1, bus_byte_en=1100, bus_wdata=0xABCDABCD. SB at 0x301 -> byte_en=0010.
- Faults: LW at 0x401 -> d_busy=0, d_fault=1 in the same IDLE cycle, no bus strobe. Store funct3=011 and d_ren&d_wen -> same response.
- Starvation: i_ren held with back-to-back loads, DATA_STREAK_MAX=4 -> four data grants, then a fetch grant; counter then 0.
- Reset mid-transaction: nRST low while in GNT_D -> strobes, byte_en and addr go to 0 immediately; after release, pending requests are re-arbitrated from IDLE.
